chip8_gpu: RTL and testbench

Sprite-drawing engine for the CHIP-8 core. On a `draw` command it XORs an 8-pixel-wide, 1–15-line sprite from main memory into the 64×32 monochrome framebuffer. The framebuffer lives in the same 4 KB memory at 0x100–0x1FF. The block reports whether any lit pixel was erased (collision). It sits between the CPU, which issues DXYN, and the shared `mem` block, reaching memory through one read port and one write port.

---
 rtl/chip8_gpu.sv | 165 ++++++++++++++++
 tb/tb_chip8_gpu.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/chip8_gpu.sv
// CHIP-8 sprite engine: XORs an 8-pixel-wide sprite into the 64x32 framebuffer
// held at 0x100-0x1FF of the shared memory, and reports pixel collisions.
module chip8_gpu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        draw,
   input  logic [11:0] addr,
   input  logic [3:0]  lines,
   input  logic [5:0]  x,
   input  logic [4:0]  y,
   output logic        busy,
   output logic        collision,
   output logic        mem_read,
   output logic [11:0] mem_read_idx,
   input  logic [7:0]  mem_read_byte,
   input  logic        mem_read_ack,
   output logic        mem_write,
   output logic [11:0] mem_write_idx,
   output logic [7:0]  mem_write_byte
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_EMPTY,
      S_READ_SPRITE,
      S_READ_LEFT,
      S_WRITE_LEFT,
      S_READ_RIGHT,
      S_WRITE_RIGHT
   } state_t;

   state_t      state_q, state_d;
   logic [11:0] addr_q, addr_d;
   logic [3:0]  lines_q, lines_d;
   logic [5:0]  x_q, x_d;
   logic [4:0]  y_q, y_d;
   logic [3:0]  line_q, line_d;
   logic [7:0]  sprite_q, sprite_d;
   logic [7:0]  fb_q, fb_d;
   logic        coll_q, coll_d;

   logic [15:0] wide;
   logic [7:0]  pat_left, pat_right;
   logic [4:0]  row;
   logic [11:0] idx_left, idx_right;
   state_t      after_line;

   // The sprite byte shifted right by x[2:0] spills into the next byte column;
   // the upper half lands in the left byte, the lower half in the right byte.
   assign wide      = {sprite_q, 8'h00} >> x_q[2:0];
   assign pat_left  = wide[15:8];
   assign pat_right = wide[7:0];
   assign row       = y_q + {1'b0, line_q};
   assign idx_left  = {4'h1, row, x_q[5:3]};
   assign idx_right = {4'h1, row, x_q[5:3] + 3'd1};
   assign after_line = (line_q == lines_q - 4'd1) ? S_IDLE : S_READ_SPRITE;

   assign busy      = (state_q != S_IDLE);
   assign collision = coll_q;

   // NOTE: every comb output gets a default first so no path infers a latch.
   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      lines_d        = lines_q;
      x_d            = x_q;
      y_d            = y_q;
      line_d         = line_q;
      sprite_d       = sprite_q;
      fb_d           = fb_q;
      coll_d         = coll_q;
      mem_read       = 1'b0;
      mem_read_idx   = 12'h000;
      mem_write      = 1'b0;
      mem_write_idx  = 12'h000;
      mem_write_byte = 8'h00;

      case (state_q)
         S_IDLE: begin
            if (draw) begin
               addr_d  = addr;
               lines_d = lines;
               x_d     = x;
               y_d     = y;
               line_d  = 4'd0;
               coll_d  = 1'b0;
               state_d = (lines == 4'd0) ? S_EMPTY : S_READ_SPRITE;
            end
         end
         S_EMPTY: state_d = S_IDLE;
         S_READ_SPRITE: begin
            // Request drops in the ack cycle so memory never sees a second read.
            mem_read     = ~mem_read_ack;
            mem_read_idx = addr_q + {8'h00, line_q};
            if (mem_read_ack) begin
               sprite_d = mem_read_byte;
               state_d  = S_READ_LEFT;
            end
         end
         S_READ_LEFT: begin
            mem_read     = ~mem_read_ack;
            mem_read_idx = idx_left;
            if (mem_read_ack) begin
               fb_d    = mem_read_byte;
               state_d = S_WRITE_LEFT;
            end
         end
         S_WRITE_LEFT: begin
            mem_write      = 1'b1;
            mem_write_idx  = idx_left;
            mem_write_byte = fb_q ^ pat_left;
            if ((fb_q & pat_left) != 8'h00) coll_d = 1'b1;
            if (x_q[2:0] != 3'd0) begin
               state_d = S_READ_RIGHT;
            end else begin
               state_d = after_line;
               line_d  = line_q + 4'd1;
            end
         end
         S_READ_RIGHT: begin
            mem_read     = ~mem_read_ack;
            mem_read_idx = idx_right;
            if (mem_read_ack) begin
               fb_d    = mem_read_byte;
               state_d = S_WRITE_RIGHT;
            end
         end
         S_WRITE_RIGHT: begin
            mem_write      = 1'b1;
            mem_write_idx  = idx_right;
            mem_write_byte = fb_q ^ pat_right;
            if ((fb_q & pat_right) != 8'h00) coll_d = 1'b1;
            state_d = after_line;
            line_d  = line_q + 4'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         addr_q   <= 12'h000;
         lines_q  <= 4'd0;
         x_q      <= 6'd0;
         y_q      <= 5'd0;
         line_q   <= 4'd0;
         sprite_q <= 8'h00;
         fb_q     <= 8'h00;
         coll_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         lines_q  <= lines_d;
         x_q      <= x_d;
         y_q      <= y_d;
         line_q   <= line_d;
         sprite_q <= sprite_d;
         fb_q     <= fb_d;
         coll_q   <= coll_d;
      end
   end

endmodule

// File: tb/tb_chip8_gpu.sv
// Directed bench for chip8_gpu with a 1-cycle-latency memory model attached.
module tb_chip8_gpu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        draw = 1'b0;
   logic [11:0] addr = 12'h000;
   logic [3:0]  lines = 4'd0;
   logic [5:0]  x = 6'd0;
   logic [4:0]  y = 5'd0;
   logic        busy, collision;
   logic        mem_read, mem_write;
   logic [11:0] mem_read_idx, mem_write_idx;
   logic [7:0]  mem_read_byte = 8'h00;
   logic        mem_read_ack = 1'b0;
   logic [7:0]  mem_write_byte;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] mem [4096];
   logic       init_done = 1'b0;
   int         write_count = 0;
   int         overlap_count = 0;
   int         stray_count = 0;

   chip8_gpu dut (
      .clk(clk), .rst_n(rst_n), .draw(draw), .addr(addr), .lines(lines),
      .x(x), .y(y), .busy(busy), .collision(collision),
      .mem_read(mem_read), .mem_read_idx(mem_read_idx),
      .mem_read_byte(mem_read_byte), .mem_read_ack(mem_read_ack),
      .mem_write(mem_write), .mem_write_idx(mem_write_idx),
      .mem_write_byte(mem_write_byte)
   );

   always #5 clk = ~clk;

   // Memory model: zeroed, sprite FF,C3,C3,C3,FF at 0x42.
   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
         mem[12'h042] <= 8'hFF;
         mem[12'h043] <= 8'hC3;
         mem[12'h044] <= 8'hC3;
         mem[12'h045] <= 8'hC3;
         mem[12'h046] <= 8'hFF;
         init_done    <= 1'b1;
      end else begin
         mem_read_ack  <= mem_read;
         mem_read_byte <= mem[mem_read_idx];
         if (mem_write) begin
            mem[mem_write_idx] <= mem_write_byte;
            write_count <= write_count + 1;
            if (mem_write_idx[11:8] != 4'h1) stray_count <= stray_count + 1;
         end
         if (mem_read && mem_write) overlap_count <= overlap_count + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic start_draw(input logic [11:0] a, input logic [3:0] l,
                             input logic [5:0] xx, input logic [4:0] yy);
      @(negedge clk);
      addr = a; lines = l; x = xx; y = yy; draw = 1'b1;
      @(negedge clk);
      draw = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 400) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic do_draw(input string tag, input logic [11:0] a, input logic [3:0] l,
                          input logic [5:0] xx, input logic [4:0] yy);
      start_draw(a, l, xx, yy);
      wait_idle(tag);
   endtask

   task automatic check_pair(input string tag, input logic [11:0] ia, input logic [11:0] ib,
                             input logic [15:0] exp);
      check(tag, {16'd0, mem[ia], mem[ib]}, {16'd0, exp});
   endtask

   int w0;

   initial begin
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_coll", {31'd0, collision}, 32'd0);
      check("rst_rd", {31'd0, mem_read}, 32'd0);
      check("rst_wr", {31'd0, mem_write}, 32'd0);
      check("rst_idx", {8'd0, mem_read_idx, mem_write_idx}, 32'd0);
      check("rst_wbyte", {24'd0, mem_write_byte}, 32'd0);
      rst_n = 1'b1;

      // Aligned draw at origin, then redraw to erase.
      start_draw(12'h042, 4'd5, 6'd0, 5'd0);
      check("busy_rise", {31'd0, busy}, 32'd1);
      wait_idle("d0");
      check("d0_r0", {24'd0, mem[12'h100]}, 32'hFF);
      check("d0_r1", {24'd0, mem[12'h108]}, 32'hC3);
      check("d0_r2", {24'd0, mem[12'h110]}, 32'hC3);
      check("d0_r3", {24'd0, mem[12'h118]}, 32'hC3);
      check("d0_r4", {24'd0, mem[12'h120]}, 32'hFF);
      check("d0_coll", {31'd0, collision}, 32'd0);
      do_draw("d0b", 12'h042, 4'd5, 6'd0, 5'd0);
      check("d0b_bytes", {mem[12'h100], mem[12'h108], mem[12'h110], mem[12'h118]}, 32'd0);
      check("d0b_r4", {24'd0, mem[12'h120]}, 32'd0);
      check("d0b_coll", {31'd0, collision}, 32'd1);

      // Vertical wrap from row 28 back to row 0.
      do_draw("vw", 12'h042, 4'd5, 6'd0, 5'd28);
      check("vw_bytes", {mem[12'h1E0], mem[12'h1E8], mem[12'h1F0], mem[12'h1F8]}, 32'hFFC3C3C3);
      check("vw_r0", {24'd0, mem[12'h100]}, 32'hFF);
      check("vw_coll", {31'd0, collision}, 32'd0);
      do_draw("vwb", 12'h042, 4'd5, 6'd0, 5'd28);
      check("vwb_bytes", {mem[12'h1E0], mem[12'h1E8], mem[12'h1F0], mem[12'h1F8]}, 32'd0);
      check("vwb_r0", {24'd0, mem[12'h100]}, 32'd0);
      check("vwb_coll", {31'd0, collision}, 32'd1);

      // Unaligned draw at x=5.
      do_draw("u5", 12'h042, 4'd5, 6'd5, 5'd0);
      check_pair("u5_r0", 12'h100, 12'h101, 16'h07F8);
      check_pair("u5_r1", 12'h108, 12'h109, 16'h0618);
      check_pair("u5_r2", 12'h110, 12'h111, 16'h0618);
      check_pair("u5_r3", 12'h118, 12'h119, 16'h0618);
      check_pair("u5_r4", 12'h120, 12'h121, 16'h07F8);
      check("u5_coll", {31'd0, collision}, 32'd0);
      do_draw("u5b", 12'h042, 4'd5, 6'd5, 5'd0);
      check_pair("u5b_r0", 12'h100, 12'h101, 16'h0000);

      // Horizontal wrap at x=61: right half lands in column 0 of the same row.
      do_draw("hw", 12'h042, 4'd5, 6'd61, 5'd0);
      check_pair("hw_r0", 12'h107, 12'h100, 16'h07F8);
      check_pair("hw_r1", 12'h10F, 12'h108, 16'h0618);
      check_pair("hw_r2", 12'h117, 12'h110, 16'h0618);
      check_pair("hw_r3", 12'h11F, 12'h118, 16'h0618);
      check_pair("hw_r4", 12'h127, 12'h120, 16'h07F8);
      check("hw_no_r1c1", {24'd0, mem[12'h109]}, 32'd0);
      check("hw_coll", {31'd0, collision}, 32'd0);
      do_draw("hwb", 12'h042, 4'd5, 6'd61, 5'd0);
      check_pair("hwb_r0", 12'h107, 12'h100, 16'h0000);

      // Draw pulsed while busy is ignored.
      w0 = write_count;
      start_draw(12'h042, 4'd1, 6'd0, 5'd0);
      @(negedge clk);
      addr = 12'h043; lines = 4'd3; x = 6'd8; y = 5'd1; draw = 1'b1;
      @(negedge clk);
      draw = 1'b0;
      wait_idle("ign");
      repeat (3) @(negedge clk);
      check("ign_r0", {24'd0, mem[12'h100]}, 32'hFF);
      check("ign_other", {24'd0, mem[12'h109]}, 32'd0);
      check("ign_busy", {31'd0, busy}, 32'd0);
      check("ign_writes", write_count - w0, 32'd1);
      do_draw("ignb", 12'h042, 4'd1, 6'd0, 5'd0);
      check("ignb_coll", {31'd0, collision}, 32'd1);

      // lines=0: one busy cycle, no traffic, collision cleared.
      w0 = write_count;
      start_draw(12'h042, 4'd0, 6'd0, 5'd0);
      check("l0_busy1", {31'd0, busy}, 32'd1);
      @(negedge clk);
      check("l0_busy0", {31'd0, busy}, 32'd0);
      check("l0_coll", {31'd0, collision}, 32'd0);
      check("l0_writes", write_count - w0, 32'd0);

      // Reset mid-draw aborts immediately.
      start_draw(12'h042, 4'd5, 6'd3, 5'd4);
      repeat (4) @(negedge clk);
      check("mid_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_req", {30'd0, mem_read, mem_write}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      check("no_rd_wr_overlap", overlap_count, 32'd0);
      check("no_stray_writes", stray_count, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
